// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for pipelined_cla_addsub.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovfl;
  logic             zero;
  logic             neg;

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, result, cout, ovfl, zero, neg
  );

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, result, cout, ovfl, zero, neg
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Two-stage add/sub with optional saturation.
// Stage 1 adds the low half; stage 2 adds the high half from the registered carry.

// 4-bit carry-lookahead nibble with group propagate/generate.
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] p, g, c;

  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c;
    p_o  = &p;
    g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

// One half-width adder: nibble array plus a flat lookahead over the nibble groups.
module cla_half #(
  parameter int H = 8
) (
  input  logic [H-1:0] a_i,
  input  logic [H-1:0] b_i,
  input  logic         c_i,
  output logic [H-1:0] sum_o,
  output logic         cout_o
);
  localparam int N = H / 4;

  logic [N-1:0] gp, gg;
  logic [N:0]   nc;
  logic         prod;

  for (genvar k = 0; k < N; k++) begin : g_nib
    cla4 u_nib (
      .a_i (a_i[4*k +: 4]),
      .b_i (b_i[4*k +: 4]),
      .c_i (nc[k]),
      .s_o (sum_o[4*k +: 4]),
      .p_o (gp[k]),
      .g_o (gg[k])
    );
  end

  // Each nibble carry is a sum of products of group terms, so no carry ripples between nibbles.
  always_comb begin
    nc    = '0;
    prod  = 1'b0;
    nc[0] = c_i;
    for (int k = 1; k <= N; k++) begin
      for (int j = -1; j < k; j++) begin
        prod = (j < 0) ? c_i : gg[j];
        for (int m = j + 1; m < k; m++) prod = prod & gp[m];
        nc[k] = nc[k] | prod;
      end
    end
  end

  assign cout_o = nc[N];
endmodule

module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_cla_addsub_if.slave bus
);
  localparam int H = WIDTH / 2;

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("pipelined_cla_addsub: WIDTH must be a multiple of 8 and at least 8");
  end

  logic [2:1]       vld_pipe_q, vld_pipe_d;
  logic             s2_ready, in_ready;

  // Stage-1 state
  logic [H-1:0]     s1_lo_q, s1_a_hi_q, s1_b_hi_q;
  logic             s1_c_q, s1_sat_q;
  logic [WIDTH-1:0] b_c;
  logic             c0;
  logic [H-1:0]     lo_sum;
  logic             lo_c;

  // Stage-2 state
  logic [WIDTH-1:0] res_q, res_d, raw;
  logic             cout_q, cout_d, ovfl_q, ovfl_d, zero_q, zero_d, neg_q, neg_d;
  logic [H-1:0]     hi_sum;
  logic             hi_c, cmsb;

  assign s2_ready    = !vld_pipe_q[2] || bus.out_ready;
  assign in_ready    = !vld_pipe_q[1] || s2_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    vld_pipe_d[1] = in_ready ? bus.in_valid : vld_pipe_q[1];
    vld_pipe_d[2] = s2_ready ? vld_pipe_q[1] : vld_pipe_q[2];
  end

  // Sub modes invert b and force carry-in 1; saturating add forces 0.
  always_comb begin
    b_c = bus.mode[0] ? ~bus.b : bus.b;
    c0  = (bus.mode == 2'b00) ? bus.cin : bus.mode[0];
  end

  cla_half #(.H(H)) u_lo (
    .a_i    (bus.a[H-1:0]),
    .b_i    (b_c[H-1:0]),
    .c_i    (c0),
    .sum_o  (lo_sum),
    .cout_o (lo_c)
  );

  cla_half #(.H(H)) u_hi (
    .a_i    (s1_a_hi_q),
    .b_i    (s1_b_hi_q),
    .c_i    (s1_c_q),
    .sum_o  (hi_sum),
    .cout_o (hi_c)
  );

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  always_comb begin
    raw    = {hi_sum, s1_lo_q};
    cmsb   = hi_sum[H-1] ^ s1_a_hi_q[H-1] ^ s1_b_hi_q[H-1];
    cout_d = hi_c;
    ovfl_d = cmsb ^ hi_c;
    res_d  = raw;
    if (s1_sat_q && ovfl_d)
      res_d = s1_a_hi_q[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    zero_d = (res_d == '0);
    neg_d  = res_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_lo_q    <= '0;
      s1_a_hi_q  <= '0;
      s1_b_hi_q  <= '0;
      s1_c_q     <= 1'b0;
      s1_sat_q   <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      ovfl_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      if (in_ready && bus.in_valid) begin
        s1_lo_q   <= lo_sum;
        s1_c_q    <= lo_c;
        s1_a_hi_q <= bus.a[WIDTH-1:H];
        s1_b_hi_q <= b_c[WIDTH-1:H];
        s1_sat_q  <= bus.mode[1];
      end
      if (s2_ready && vld_pipe_q[1]) begin
        res_q  <= res_d;
        cout_q <= cout_d;
        ovfl_q <= ovfl_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
      end
    end
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovfl      = ovfl_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 8 and at least 8; other values SHALL be a synthesis-time error.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 a  input  WIDTH  operand A, two's complement.
REQ-007 b  input  WIDTH  operand B, two's complement.
REQ-008 cin  input  1  carry-in; used only in plain add mode.
REQ-009 mode  input  2  operation: 00 add, 01 sub, 10 saturating add, 11 saturating sub.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  sum/difference, saturated in modes 1x.
REQ-013 cout  output  1  unsigned carry-out of MSB (for sub, 1 = no borrow).
REQ-014 ovfl  output  1  signed overflow of the unsaturated operation.
REQ-015 zero  output  1  result == 0.
REQ-016 neg  output  1  result MSB.

Function
REQ-017 Transfer in: a beat SHALL be accepted exactly in cycles where in_valid && in_ready; transfer out exactly where out_valid && out_ready.
REQ-018 Sub modes SHALL invert b and force carry-in to 1; cin SHALL be ignored in modes 01, 10, 11 (mode 10 uses carry-in 0).
REQ-019 Adder SHALL be built from 4-bit carry-lookahead nibbles with group propagate/generate combined by lookahead within each half; no ripple across nibbles within a half.
REQ-020 Stage 1 SHALL compute the low WIDTH/2 bits and their carry-out, registering low sum, that carry, upper operand halves (b already conditioned), and mode.
REQ-021 Stage 2 SHALL compute the upper half using the registered carry, then overflow, saturation and flags, registering all outputs.
REQ-022 Latency SHALL be exactly 2 cycles from accept to out_valid with out_ready held high; throughput one beat per cycle.
REQ-023 ovfl SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-024 In modes 1x with ovfl=1, result SHALL be 2^(WIDTH-1)-1 if operand A is non-negative, else -2^(WIDTH-1); without overflow result SHALL equal the plain result.
REQ-025 zero and neg SHALL be derived from the final (possibly saturated) result; cout and ovfl from the unsaturated operation.
REQ-026 Handshake: s2_ready = !out_valid || out_ready; in_ready = !s1_valid || s2_ready; a stage SHALL load only when its ready is high and hold otherwise.
REQ-027 While out_valid && !out_ready, all result/flag outputs SHALL remain stable.
REQ-028 With out_ready low, exactly two beats SHALL be absorbed before in_ready deasserts; none SHALL be lost or duplicated.
REQ-029 Simultaneous output transfer and input accept in a full pipeline SHALL advance both stages in the same cycle.
REQ-030 in_ready SHALL depend only on registered state and out_ready (no path from in_valid).

Reset
REQ-031 When rst_n is low at a clock edge, both stage valids SHALL clear, and out_valid, result, cout, ovfl, zero, neg SHALL be 0 after that edge.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; no output transfer SHALL occur in the cycle after reset.
REQ-033 in_ready SHALL be 1 in the first cycle after reset is released.

Verification (WIDTH=16)
REQ-034 mode 00, a=0x7FFF, b=0x0001, cin=0 -> 2 cycles later result=0x8000, ovfl=1, neg=1, cout=0, zero=0.
REQ-035 mode 10, a=0x7FFF, b=0x0001 -> result=0x7FFF, ovfl=1, neg=0; mode 11, a=0x8000, b=0x0001 -> result=0x8000, ovfl=1.
REQ-036 mode 01, a=0x1234, b=0x1234 -> result=0x0000, zero=1, cout=1; a=0x0000, b=0x0001 -> result=0xFFFF, cout=0, neg=1.
REQ-037 mode 00, a=0x00FF, b=0x0001, cin=1 -> result=0x0101 (carry crosses half boundary via stage-1 register).
REQ-038 out_ready=0, in_valid=1 continuous with 3 distinct beats -> two accepted, in_ready=0, outputs stable; out_ready=1 -> beats emerge in order, one per cycle.
REQ-039 Two beats in flight, rst_n=0 for one edge -> out_valid=0, all outputs 0, in_ready=1 after release; no stale beat appears.
